// File: rtl/marker_vector_scheduler_if.sv
// marker_vector_scheduler_if
// Bundles the frame/centroid inputs and the issue/status outputs of
// marker_vector_scheduler.
//   master : the side producing frame_start/centroids and observing results
//   slave  : the scheduler itself
// Signals per colour C in {red, purple, green, blue}:
//   C_x_com_in / C_y_com_in / valid_C_in    centroid from the colour detector
//   C_x_com_out / C_y_com_out / valid_C_out latched centroid + issue strobe
// Shared: frame_start_in, vec_ready_out, busy_out,
//         dropped_count_out (8b, saturating), issued_count_out (16b, wrapping)
interface marker_vector_scheduler_if;
    logic        frame_start_in;

    logic [10:0] red_x_com_in;
    logic [9:0]  red_y_com_in;
    logic        valid_red_in;
    logic [10:0] purple_x_com_in;
    logic [9:0]  purple_y_com_in;
    logic        valid_purple_in;
    logic [10:0] green_x_com_in;
    logic [9:0]  green_y_com_in;
    logic        valid_green_in;
    logic [10:0] blue_x_com_in;
    logic [9:0]  blue_y_com_in;
    logic        valid_blue_in;

    logic [10:0] red_x_com_out;
    logic [9:0]  red_y_com_out;
    logic        valid_red_out;
    logic [10:0] purple_x_com_out;
    logic [9:0]  purple_y_com_out;
    logic        valid_purple_out;
    logic [10:0] green_x_com_out;
    logic [9:0]  green_y_com_out;
    logic        valid_green_out;
    logic [10:0] blue_x_com_out;
    logic [9:0]  blue_y_com_out;
    logic        valid_blue_out;

    logic        vec_ready_out;
    logic        busy_out;
    logic [7:0]  dropped_count_out;
    logic [15:0] issued_count_out;

    modport master (
        output frame_start_in,
        output red_x_com_in, red_y_com_in, valid_red_in,
        output purple_x_com_in, purple_y_com_in, valid_purple_in,
        output green_x_com_in, green_y_com_in, valid_green_in,
        output blue_x_com_in, blue_y_com_in, valid_blue_in,
        input  red_x_com_out, red_y_com_out, valid_red_out,
        input  purple_x_com_out, purple_y_com_out, valid_purple_out,
        input  green_x_com_out, green_y_com_out, valid_green_out,
        input  blue_x_com_out, blue_y_com_out, valid_blue_out,
        input  vec_ready_out, busy_out, dropped_count_out, issued_count_out
    );

    modport slave (
        input  frame_start_in,
        input  red_x_com_in, red_y_com_in, valid_red_in,
        input  purple_x_com_in, purple_y_com_in, valid_purple_in,
        input  green_x_com_in, green_y_com_in, valid_green_in,
        input  blue_x_com_in, blue_y_com_in, valid_blue_in,
        output red_x_com_out, red_y_com_out, valid_red_out,
        output purple_x_com_out, purple_y_com_out, valid_purple_out,
        output green_x_com_out, green_y_com_out, valid_green_out,
        output blue_x_com_out, blue_y_com_out, valid_blue_out,
        output vec_ready_out, busy_out, dropped_count_out, issued_count_out
    );
endinterface

// File: rtl/marker_vector_scheduler.sv
// marker_vector_scheduler
// Collects one centroid per marker colour (red, purple, green, blue), issues
// the complete set to the downstream `vectors` block in a single cycle, then
// waits CALC_CYCLES+1 cycles for it to settle before flagging vec_ready_out.
// Incomplete frames are discarded on frame_start and counted.
// Ports:
//   clk_in  : system clock, all state on rising edge
//   rst_in  : synchronous active-high reset
//   bus     : marker_vector_scheduler_if.slave (centroids in, latched
//             centroids / strobes / status out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | latching centroid strobes, building have_mask
// ISSUE   | one cycle: all valid_C_out high, count issue, load timer
// WAIT    | timer counts down; vec_ready_out pulses when it hits zero
module marker_vector_scheduler #(
    parameter int unsigned CALC_CYCLES = 16
) (
    input logic                       clk_in,
    input logic                       rst_in,
    marker_vector_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2
    } state_t;

    localparam logic [7:0] CALC_LOAD = 8'(CALC_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  have_mask_q;
    logic [7:0]  timer_q;
    logic [7:0]  dropped_q;
    logic [15:0] issued_q;
    logic [10:0] x_q [4];
    logic [9:0]  y_q [4];

    logic [3:0]  strobe;
    logic [10:0] x_in [4];
    logic [9:0]  y_in [4];
    logic [3:0]  mask_merged;
    logic        complete;
    logic        drop;

    logic        issue_strobe;
    logic        busy;
    logic        vec_ready;

    // Colour index order: red=0, purple=1, green=2, blue=3
    assign strobe = {bus.valid_blue_in, bus.valid_green_in,
                     bus.valid_purple_in, bus.valid_red_in};
    assign x_in[0] = bus.red_x_com_in;
    assign x_in[1] = bus.purple_x_com_in;
    assign x_in[2] = bus.green_x_com_in;
    assign x_in[3] = bus.blue_x_com_in;
    assign y_in[0] = bus.red_y_com_in;
    assign y_in[1] = bus.purple_y_com_in;
    assign y_in[2] = bus.green_y_com_in;
    assign y_in[3] = bus.blue_y_com_in;

    // Strobes in the current cycle count toward completion, and completion
    // takes priority over a simultaneous frame_start.
    assign mask_merged = have_mask_q | strobe;
    assign complete    = (state_q == COLLECT) && (mask_merged == 4'hF);
    assign drop        = (state_q == COLLECT) && bus.frame_start_in &&
                         (have_mask_q != 4'h0) && !complete;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (complete) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (timer_q == 8'd0) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output logic
    always_comb begin
        issue_strobe = 1'b0;
        busy         = 1'b0;
        vec_ready    = 1'b0;
        case (state_q)
            ISSUE: begin
                issue_strobe = 1'b1;
                busy         = 1'b1;
            end
            WAIT: begin
                busy      = 1'b1;
                vec_ready = (timer_q == 8'd0);
            end
            default: ;
        endcase
    end

    // Datapath: mask, coordinates, timer and counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            have_mask_q <= 4'h0;
            timer_q     <= 8'd0;
            dropped_q   <= 8'd0;
            issued_q    <= 16'd0;
            for (int c = 0; c < 4; c++) begin
                x_q[c] <= 11'd0;
                y_q[c] <= 10'd0;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    for (int c = 0; c < 4; c++) begin
                        if (strobe[c]) begin
                            x_q[c] <= x_in[c];
                            y_q[c] <= y_in[c];
                        end
                    end
                    // A dropping frame_start restarts the mask with whatever
                    // strobes arrived alongside it.
                    if (drop) begin
                        have_mask_q <= strobe;
                        if (dropped_q != 8'hFF) begin
                            dropped_q <= dropped_q + 8'd1;
                        end
                    end else begin
                        have_mask_q <= mask_merged;
                    end
                end
                ISSUE: begin
                    have_mask_q <= 4'h0;
                    issued_q    <= issued_q + 16'd1;
                    timer_q     <= CALC_LOAD;
                end
                WAIT: begin
                    if (timer_q != 8'd0) begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.red_x_com_out    = x_q[0];
    assign bus.red_y_com_out    = y_q[0];
    assign bus.purple_x_com_out = x_q[1];
    assign bus.purple_y_com_out = y_q[1];
    assign bus.green_x_com_out  = x_q[2];
    assign bus.green_y_com_out  = y_q[2];
    assign bus.blue_x_com_out   = x_q[3];
    assign bus.blue_y_com_out   = y_q[3];

    assign bus.valid_red_out    = issue_strobe;
    assign bus.valid_purple_out = issue_strobe;
    assign bus.valid_green_out  = issue_strobe;
    assign bus.valid_blue_out   = issue_strobe;

    assign bus.vec_ready_out     = vec_ready;
    assign bus.busy_out          = busy;
    assign bus.dropped_count_out = dropped_q;
    assign bus.issued_count_out  = issued_q;

endmodule

// File: tb/tb_marker_vector_scheduler.sv
module tb_marker_vector_scheduler;

    localparam int CALC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    marker_vector_scheduler_if bus ();

    marker_vector_scheduler #(.CALC_CYCLES(CALC)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Bench-side stimulus, colour index red=0 purple=1 green=2 blue=3
    logic [3:0]  strb = 4'h0;
    logic        fs   = 1'b0;
    logic [10:0] xin [4];
    logic [9:0]  yin [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push();
        bus.frame_start_in  = fs;
        bus.valid_red_in    = strb[0];
        bus.valid_purple_in = strb[1];
        bus.valid_green_in  = strb[2];
        bus.valid_blue_in   = strb[3];
        bus.red_x_com_in    = xin[0];
        bus.red_y_com_in    = yin[0];
        bus.purple_x_com_in = xin[1];
        bus.purple_y_com_in = yin[1];
        bus.green_x_com_in  = xin[2];
        bus.green_y_com_in  = yin[2];
        bus.blue_x_com_in   = xin[3];
        bus.blue_y_com_in   = yin[3];
    endtask

    task automatic step();
        push();
        @(posedge clk);
        #1;
        strb = 4'h0;
        fs   = 1'b0;
        rst  = 1'b0;
        push();
    endtask

    task automatic drive(input logic [3:0] s, input logic f);
        strb = s;
        fs   = f;
        step();
    endtask

    task automatic set_xy(input int c, input int x, input int y);
        xin[c] = 11'(x);
        yin[c] = 10'(y);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy_out === 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk("idle_timeout", {31'd0, bus.busy_out}, 32'd0);
    endtask

    // Behavioural model: an issue is scheduled at an absolute cycle number;
    // everything during the settle window follows from cycle arithmetic.
    longint      cyc = 0;
    longint      issue_cyc = -1000;
    bit          armed = 0;
    logic [3:0]  m_have = 4'h0;
    logic [7:0]  m_dropped = 8'd0;
    logic [15:0] m_issued = 16'd0;
    logic [10:0] mx [4];
    logic [9:0]  my [4];

    function automatic bit m_busy(input longint n);
        return (n >= issue_cyc) && (n <= issue_cyc + CALC + 1);
    endfunction

    always @(posedge clk) begin
        longint n;
        logic [3:0] merged;
        n = cyc;
        if (rst) begin
            armed     = 1;
            issue_cyc = -1000;
            m_have    = 4'h0;
            m_dropped = 8'd0;
            m_issued  = 16'd0;
            for (int c = 0; c < 4; c++) begin
                mx[c] = 11'd0;
                my[c] = 10'd0;
            end
        end else if (!armed) begin
        end else if (n == issue_cyc) begin
            m_issued = m_issued + 16'd1;
        end else if (!m_busy(n)) begin
            merged = m_have | strb;
            if (merged == 4'hF) begin
                issue_cyc = n + 1;
                m_have    = 4'h0;
            end else if (fs && m_have != 4'h0) begin
                m_have = strb;
                if (m_dropped != 8'd255) m_dropped = m_dropped + 8'd1;
            end else begin
                m_have = merged;
            end
            for (int c = 0; c < 4; c++) begin
                if (strb[c]) begin
                    mx[c] = xin[c];
                    my[c] = yin[c];
                end
            end
        end
        cyc = cyc + 1;
    end

    logic [10:0] dx [4];
    logic [9:0]  dy [4];
    assign dx[0] = bus.red_x_com_out;
    assign dx[1] = bus.purple_x_com_out;
    assign dx[2] = bus.green_x_com_out;
    assign dx[3] = bus.blue_x_com_out;
    assign dy[0] = bus.red_y_com_out;
    assign dy[1] = bus.purple_y_com_out;
    assign dy[2] = bus.green_y_com_out;
    assign dy[3] = bus.blue_y_com_out;

    always @(negedge clk) begin
        if (armed) begin
            logic [3:0] dv;
            dv = {bus.valid_blue_out, bus.valid_green_out, bus.valid_purple_out, bus.valid_red_out};
            chk("valid_out", {28'd0, dv}, (cyc == issue_cyc) ? 32'hF : 32'h0);
            chk("vec_ready", {31'd0, bus.vec_ready_out}, {31'd0, (cyc == issue_cyc + CALC + 1)});
            chk("busy", {31'd0, bus.busy_out}, {31'd0, m_busy(cyc)});
            chk("dropped", {24'd0, bus.dropped_count_out}, {24'd0, m_dropped});
            chk("issued", {16'd0, bus.issued_count_out}, {16'd0, m_issued});
            for (int c = 0; c < 4; c++) begin
                chk("coord", {11'd0, dx[c], dy[c]}, {11'd0, mx[c], my[c]});
            end
        end
    end

    initial begin
        int lat;
        bit seen;
        for (int c = 0; c < 4; c++) set_xy(c, 0, 0);
        push();
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("reset_issued", {16'd0, bus.issued_count_out}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy_out}, 32'd0);

        // All four colours in one cycle
        set_xy(0, 300, 300);
        set_xy(1, 300, 200);
        set_xy(2, 400, 300);
        set_xy(3, 250, 350);
        drive(4'hF, 1'b0);
        chk("s1_valid_red", {31'd0, bus.valid_red_out}, 32'd1);
        chk("s1_valid_blue", {31'd0, bus.valid_blue_out}, 32'd1);
        chk("s1_busy", {31'd0, bus.busy_out}, 32'd1);
        chk("s1_red", {11'd0, bus.red_x_com_out, bus.red_y_com_out}, {11'd0, 11'd300, 10'd300});
        chk("s1_purple", {11'd0, bus.purple_x_com_out, bus.purple_y_com_out}, {11'd0, 11'd300, 10'd200});
        chk("s1_green", {11'd0, bus.green_x_com_out, bus.green_y_com_out}, {11'd0, 11'd400, 10'd300});
        chk("s1_blue", {11'd0, bus.blue_x_com_out, bus.blue_y_com_out}, {11'd0, 11'd250, 10'd350});
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.vec_ready_out === 1'b1 && lat < 0) lat = k;
        end
        chk("s1_latency", lat, 32'd17);
        chk("s1_issued", {16'd0, bus.issued_count_out}, 32'd1);
        chk("s1_model_issued", {16'd0, m_issued}, 32'd1);
        wait_idle();

        // Staggered strobes with a red resend
        set_xy(0, 100, 101);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        set_xy(0, 310, 102);
        drive(4'b0001, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0010, 1'b0);
        chk("s2_issue_t10", {31'd0, bus.valid_red_out}, 32'd1);
        chk("s2_red_x", {21'd0, bus.red_x_com_out}, 32'd310);
        wait_idle();

        // Drop on incomplete frame, then a normal issue, then saturation
        drive(4'b0101, 1'b0);
        drive(4'b0000, 1'b1);
        chk("s3_dropped1", {24'd0, bus.dropped_count_out}, 32'd1);
        drive(4'b0001, 1'b0);
        drive(4'b1110, 1'b0);
        chk("s3_issue_after_drop", {31'd0, bus.valid_green_out}, 32'd1);
        wait_idle();
        for (int i = 0; i < 299; i++) begin
            drive(4'b0001, 1'b0);
            drive(4'b0000, 1'b1);
        end
        chk("s3_saturated", {24'd0, bus.dropped_count_out}, 32'd255);
        chk("s3_model_saturated", {24'd0, m_dropped}, 32'd255);

        // Completion beats a simultaneous frame_start
        drive(4'b1101, 1'b0);
        drive(4'b0010, 1'b1);
        chk("s4_issue", {31'd0, bus.valid_purple_out}, 32'd1);
        chk("s4_no_drop", {24'd0, bus.dropped_count_out}, 32'd255);
        wait_idle();

        // Strobes during WAIT are ignored
        set_xy(0, 500, 50);
        drive(4'hF, 1'b0);
        drive(4'h0, 1'b0);
        set_xy(0, 777, 77);
        set_xy(2, 666, 66);
        drive(4'hF, 1'b0);
        drive(4'b0101, 1'b0);
        chk("s5_red_held", {11'd0, bus.red_x_com_out, bus.red_y_com_out}, {11'd0, 11'd500, 10'd50});
        wait_idle();
        drive(4'b1101, 1'b0);
        chk("s5_mask_empty", {31'd0, bus.busy_out}, 32'd0);
        drive(4'b0010, 1'b0);
        chk("s5_issue", {31'd0, bus.valid_blue_out}, 32'd1);
        wait_idle();

        // Reset five cycles into WAIT
        drive(4'hF, 1'b0);
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        chk("s6_busy0", {31'd0, bus.busy_out}, 32'd0);
        chk("s6_issued0", {16'd0, bus.issued_count_out}, 32'd0);
        chk("s6_dropped0", {24'd0, bus.dropped_count_out}, 32'd0);
        chk("s6_coord0", {11'd0, bus.red_x_com_out, bus.red_y_com_out}, 32'd0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.vec_ready_out !== 1'b0) seen = 1;
        end
        chk("s6_no_ready", {31'd0, seen}, 32'd0);
        drive(4'hF, 1'b0);
        wait_idle();
        chk("s6_issued1", {16'd0, bus.issued_count_out}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            for (int c = 0; c < 4; c++) begin
                xin[c] = 11'($urandom_range(0, 2047));
                yin[c] = 10'($urandom_range(0, 1023));
                strb[c] = ($urandom_range(0, 99) < 30);
            end
            fs  = ($urandom_range(0, 99) < 6);
            rst = ($urandom_range(0, 999) < 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
